prealu_q: RTL and testbench
===========================

PREALU_Q -- requirements
Module: prealu_q

Interface
REQ-001 Parameter WIDTH, default 8, datapath width of all buses and operands (legal 4..32).
REQ-002 Parameter DEPTH, default 2, operand queue depth in entries (legal 1..8).
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports db, adl, sb  input  WIDTH each  source buses.
REQ-006 Port sbwa  input  1  load A stage from sb.
REQ-007 Port zerowa  input  1  load A stage with all-zero.
REQ-008 Port dbwb  input  1  load B stage from db.
REQ-009 Port dbinvwb  input  1  load B stage from bitwise-inverted db.
REQ-010 Port adlwb  input  1  load B stage from adl.
REQ-011 Ports cin  input  1 and cinwe  input  1  carry-in value and its load enable.
REQ-012 Port push  input  1  enqueue current operand set {A, B, C}.
REQ-013 Port in_ready  output  1  queue can accept a push this cycle.
REQ-014 Ports aout, bout  output  WIDTH each, cout  output  1  head-entry operands and carry.
REQ-015 Port out_valid  output  1  head entry present; port out_ready  input  1  consumer accepts head.
REQ-016 Port count  output  clog2(DEPTH+1)  entries held in queue.
REQ-017 Port ovf  output  1  sticky flag, push attempted while full.

Function
REQ-018 A stage loads on any asserted A enable; its value is the bitwise AND of all selected A sources (zerowa present -> 0).
REQ-019 B stage loads on any asserted B enable; its value is the bitwise AND of all selected B sources (wired-AND bus rule).
REQ-020 C stage loads cin when cinwe=1; stages without an asserted enable hold their value.
REQ-021 Push accepted iff push=1 and in_ready=1; the enqueued entry holds the stage values as updated by the same cycle's enables (bypass).
REQ-022 in_ready = (count < DEPTH); it does not depend on out_ready.
REQ-023 Pop occurs iff out_valid=1 and out_ready=1; head entry removed at that edge.
REQ-024 out_valid = (count != 0); aout/bout/cout show the head entry while valid and drive 0 while empty.
REQ-025 Latency: accepted push into an empty queue yields out_valid=1 with that entry at the next cycle.
REQ-026 Simultaneous accepted push and pop: count unchanged, FIFO order preserved.
REQ-027 Push while full: entry discarded, count unchanged, ovf set to 1 at that edge and held until reset; a same-cycle pop still occurs.
REQ-028 Queue pointers wrap modulo DEPTH; order is strict FIFO across wrap.
REQ-029 Stage loads occur regardless of queue state, including when full.

Reset
REQ-030 reset=1 at a rising edge sets A, B, C stages to 0, empties the queue, clears ovf; reset overrides all other inputs that cycle.
REQ-031 After reset: count=0, out_valid=0, in_ready=1, aout=0, bout=0, cout=0, ovf=0.
REQ-032 Reset asserted mid-operation discards all queued entries; no pop or push completes that cycle.

Verification
REQ-033 Reset, then db=8'h11, dbwb=1, sb=8'h33, sbwa=1, push=1 one cycle -> next cycle out_valid=1, aout=8'h33, bout=8'h11, count=1.
REQ-034 db=8'h0F, adl=8'h3C, dbwb=1, adlwb=1 same cycle, push -> bout=8'h0C; dbinvwb=1 alone with db=8'h11 -> bout=8'hEE.
REQ-035 DEPTH=2, out_ready=0, three pushes (A=1,2,3) -> count=2, in_ready=0, ovf=1; then out_ready=1 -> aout 1 then 2, then out_valid=0, aout=0.
REQ-036 Queue full, push=1 and out_ready=1 same cycle -> push rejected, count 2->1, ovf=1.
REQ-037 Count=1, push and pop same cycle repeatedly for 5 cycles -> count stays 1, outputs follow FIFO order across pointer wrap.
REQ-038 Queue holding 2 entries, ovf=1, assert reset one cycle -> count=0, out_valid=0, in_ready=1, ovf=0, aout=bout=0.

Source files
------------

// File: rtl/prealu_q.sv
// prealu_q: ALU operand pre-stage (A/B/C latches) feeding a small operand FIFO
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   db, adl, sb                 source buses (WIDTH each)
//   sbwa, zerowa                A stage loads (wired-AND of selected sources)
//   dbwb, dbinvwb, adlwb        B stage loads (wired-AND of selected sources)
//   cin, cinwe                  carry stage value and load enable
//   push, in_ready              enqueue handshake for the current {A,B,C}
//   aout, bout, cout, out_valid head entry (zero while empty)
//   out_ready                   consumer pops head when out_valid is set
//   count, ovf                  occupancy and sticky push-while-full flag
module prealu_q #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           db,
  input  logic [WIDTH-1:0]           adl,
  input  logic [WIDTH-1:0]           sb,
  input  logic                       sbwa,
  input  logic                       zerowa,
  input  logic                       dbwb,
  input  logic                       dbinvwb,
  input  logic                       adlwb,
  input  logic                       cin,
  input  logic                       cinwe,
  input  logic                       push,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           aout,
  output logic [WIDTH-1:0]           bout,
  output logic                       cout,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       ovf
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] r_a, r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_qa [DEPTH];
  logic [WIDTH-1:0] r_qb [DEPTH];
  logic             r_qc [DEPTH];
  logic [PW-1:0]    r_wp, r_rp;
  logic [CW-1:0]    r_cnt;
  logic             r_ovf;
  logic [WIDTH-1:0] w_a_val, w_b_val, w_a_next, w_b_next;
  logic             w_c_next, w_push, w_pop;
  logic [PW-1:0]    w_wp_inc, w_rp_inc;
  // Several enables on one stage model a wired-AND bus: unselected sources read as all-ones
  assign w_a_val  = (sbwa ? sb : '1) & (zerowa ? '0 : '1);
  assign w_b_val  = (dbwb ? db : '1) & (dbinvwb ? ~db : '1) & (adlwb ? adl : '1);
  assign w_a_next = (sbwa | zerowa) ? w_a_val : r_a;
  assign w_b_next = (dbwb | dbinvwb | adlwb) ? w_b_val : r_b;
  assign w_c_next = cinwe ? cin : r_c;
  assign in_ready  = r_cnt < CW'(DEPTH);
  assign out_valid = r_cnt != '0;
  assign w_push    = push & in_ready;
  assign w_pop     = out_valid & out_ready;
  assign w_wp_inc  = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
  assign w_rp_inc  = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
  assign aout  = out_valid ? r_qa[r_rp] : '0;
  assign bout  = out_valid ? r_qb[r_rp] : '0;
  assign cout  = out_valid & r_qc[r_rp];
  assign count = r_cnt;
  assign ovf   = r_ovf;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_c   <= 1'b0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_a <= w_a_next;
      r_b <= w_b_next;
      r_c <= w_c_next;
      // Enqueued entry takes this cycle's stage updates (bypass)
      if (w_push) begin
        r_qa[r_wp] <= w_a_next;
        r_qb[r_wp] <= w_b_next;
        r_qc[r_wp] <= w_c_next;
        r_wp       <= w_wp_inc;
      end
      if (w_pop) r_rp <= w_rp_inc;
      if (push && !in_ready) r_ovf <= 1'b1;
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_prealu_q.sv
// tb_prealu_q: directed and randomized checks of prealu_q against a queue-based model
module tb_prealu_q;
  localparam int W = 8;
  localparam int D = 2;
  logic clk = 0;
  logic reset, sbwa, zerowa, dbwb, dbinvwb, adlwb, cin, cinwe, push, out_ready;
  logic [W-1:0] db, adl, sb;
  logic in_ready, cout, out_valid, ovf;
  logic [W-1:0] aout, bout;
  logic [$clog2(D+1)-1:0] count;
  int checks = 0;
  int errors = 0;
  typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic c; } ent_t;
  ent_t q[$];
  logic [W-1:0] ma, mb;
  logic mc, movf;

  prealu_q #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .db(db), .adl(adl), .sb(sb),
    .sbwa(sbwa), .zerowa(zerowa), .dbwb(dbwb), .dbinvwb(dbinvwb), .adlwb(adlwb),
    .cin(cin), .cinwe(cinwe), .push(push), .in_ready(in_ready),
    .aout(aout), .bout(bout), .cout(cout), .out_valid(out_valid),
    .out_ready(out_ready), .count(count), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset = 0; sbwa = 0; zerowa = 0; dbwb = 0; dbinvwb = 0; adlwb = 0;
    cin = 0; cinwe = 0; push = 0; out_ready = 0; db = 0; adl = 0; sb = 0;
  endtask

  // Model the clock edge from the rules: stages, then FIFO push/pop on pre-edge occupancy
  task automatic model_edge();
    bit do_pop, room;
    ent_t e;
    if (reset) begin
      ma = 0; mb = 0; mc = 0; movf = 0; q.delete();
      return;
    end
    do_pop = (q.size() != 0) && out_ready;
    room = q.size() < D;
    if (sbwa || zerowa) ma = zerowa ? '0 : sb;
    if (dbwb || dbinvwb || adlwb) begin
      mb = '1;
      if (dbwb) mb &= db;
      if (dbinvwb) mb &= ~db;
      if (adlwb) mb &= adl;
    end
    if (cinwe) mc = cin;
    if (do_pop) void'(q.pop_front());
    if (push) begin
      if (room) begin e.a = ma; e.b = mb; e.c = mc; q.push_back(e); end
      else movf = 1;
    end
  endtask

  task automatic compare();
    bit v;
    v = q.size() != 0;
    chk("count", 32'(count), q.size());
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("in_ready", 32'(in_ready), 32'(q.size() < D));
    chk("ovf", 32'(ovf), 32'(movf));
    chk("aout", 32'(aout), v ? 32'(q[0].a) : 0);
    chk("bout", 32'(bout), v ? 32'(q[0].b) : 0);
    chk("cout", 32'(cout), v ? 32'(q[0].c) : 0);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    idle(); reset = 1; cyc(); idle();
  endtask

  task automatic push_a(input logic [W-1:0] v);
    sb = v; sbwa = 1; push = 1; cyc(); idle();
  endtask

  initial begin
    idle();
    ma = 0; mb = 0; mc = 0; movf = 0;
    do_reset();
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_aout", 32'(aout), 0);
    // First push into empty queue appears next cycle
    db = 8'h11; dbwb = 1; sb = 8'h33; sbwa = 1; push = 1; cyc(); idle();
    chk("lat_valid", 32'(out_valid), 1);
    chk("lat_aout", 32'(aout), 32'h33);
    chk("lat_bout", 32'(bout), 32'h11);
    chk("lat_count", 32'(count), 1);
    // Wired-AND of B sources and inverted db
    do_reset();
    db = 8'h0F; adl = 8'h3C; dbwb = 1; adlwb = 1; push = 1; cyc(); idle();
    chk("and_bout", 32'(bout), 32'h0C);
    out_ready = 1; db = 8'h11; dbinvwb = 1; push = 1; cyc(); idle();
    chk("inv_bout", 32'(bout), 32'hEE);
    // Overflow with three pushes then drain
    do_reset();
    push_a(8'h01); push_a(8'h02); push_a(8'h03);
    chk("ovf_count", 32'(count), 2);
    chk("ovf_ready", 32'(in_ready), 0);
    chk("ovf_flag", 32'(ovf), 1);
    out_ready = 1; cyc();
    chk("drain_a2", 32'(aout), 2);
    cyc();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_aout", 32'(aout), 0);
    chk("drain_ovf", 32'(ovf), 1);
    idle();
    // Full with simultaneous push and pop: push rejected
    do_reset();
    push_a(8'h0A); push_a(8'h0B);
    sb = 8'h0C; sbwa = 1; push = 1; out_ready = 1; cyc(); idle();
    chk("fullpp_count", 32'(count), 1);
    chk("fullpp_ovf", 32'(ovf), 1);
    chk("fullpp_aout", 32'(aout), 32'h0B);
    // Steady push+pop across pointer wrap
    do_reset();
    push_a(8'h40);
    for (int i = 1; i <= 5; i++) begin
      sb = W'(8'h40 + i); sbwa = 1; push = 1; out_ready = 1; cyc();
      chk("wrap_count", 32'(count), 1);
      chk("wrap_aout", 32'(aout), 32'h40 + i);
    end
    idle();
    // Reset mid-operation
    push_a(8'h55); push_a(8'h66); push_a(8'h77);
    reset = 1; push = 1; out_ready = 1; cyc(); idle();
    chk("midrst_count", 32'(count), 0);
    chk("midrst_ovf", 32'(ovf), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_bout", 32'(bout), 0);
    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      reset = ($urandom_range(0, 49) == 0);
      db = W'($urandom); adl = W'($urandom); sb = W'($urandom);
      sbwa = 1'($urandom); zerowa = ($urandom_range(0, 3) == 0);
      dbwb = 1'($urandom); dbinvwb = ($urandom_range(0, 3) == 0); adlwb = 1'($urandom);
      cin = 1'($urandom); cinwe = 1'($urandom);
      push = 1'($urandom); out_ready = 1'($urandom);
      cyc();
    end
    idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
